station_access_fsm: RTL and testbench

STATION_ACCESS_FSM -- requirements
Module: station_access_fsm

---
 rtl/station_access_fsm.sv | 175 +++++++++++++++++
 tb/tb_station_access_fsm.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/station_access_fsm.sv
// -----------------------------------------------------------------------------
// station_access_fsm
//
// Keypad access controller. The user enters a code one digit at a time. A
// complete matching entry grants access for HOLD_CYCLES enabled cycles. A
// complete wrong entry pulses fail. MAX_TRIES consecutive wrong entries lock
// the station for LOCK_CYCLES enabled cycles. All outputs are registered.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset, wins over enable
//   enable      in   clock enable; low freezes every register
//   code        in   CODE_W-bit entered digit
//   code_valid  in   code carries a digit this cycle
//   abort       in   drop the partial entry without counting a try
//   secret      in   stored code, digit k at [k*CODE_W +: CODE_W], k=0 first
//   Y           out  access granted
//   fail        out  one-enabled-cycle pulse on a wrong complete entry
//   locked      out  high throughout lockout
//   digit_idx   out  digits accepted in the current entry
// -----------------------------------------------------------------------------
module station_access_fsm #(
    parameter int CODE_W      = 4,
    parameter int DIGITS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CODE_W-1:0]            code,
    input  logic                         code_valid,
    input  logic                         abort,
    input  logic [DIGITS*CODE_W-1:0]     secret,
    output logic                         Y,
    output logic                         fail,
    output logic                         locked,
    output logic [$clog2(DIGITS+1)-1:0]  digit_idx
);

    localparam int IDX_W   = $clog2(DIGITS + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        GRANT   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               err_q,    err_d;
    logic [TRY_W-1:0]   tries_q,  tries_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic               y_q,      y_d;
    logic               fail_q,   fail_d;
    logic               locked_q, locked_d;

    logic [CODE_W-1:0]  want_digit;
    logic               digit_bad;
    logic [TRY_W-1:0]   tries_inc;

    // secret is read live at the accepting edge, so a mid-entry change only
    // affects digits not yet entered.
    assign want_digit = secret[int'(idx_q) * CODE_W +: CODE_W];
    assign digit_bad  = (code != want_digit);
    assign tries_inc  = tries_q + TRY_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        tries_d  = tries_q;
        timer_d  = timer_q;
        y_d      = y_q;
        fail_d   = fail_q;
        locked_d = locked_q;

        // With enable low everything, including a pending fail pulse, holds.
        if (enable) begin
            fail_d = 1'b0;
            unique case (state_q)
                ENTRY: begin
                    if (abort) begin
                        idx_d = '0;
                        err_d = 1'b0;
                    end else if (code_valid) begin
                        if (idx_q == LAST_IDX) begin
                            // Final digit: its own mismatch counts too.
                            idx_d = '0;
                            err_d = 1'b0;
                            if (err_q || digit_bad) begin
                                fail_d  = 1'b1;
                                tries_d = tries_inc;
                                if (tries_inc == TRY_LIMIT) begin
                                    state_d  = LOCKOUT;
                                    locked_d = 1'b1;
                                    timer_d  = LOCK_LOAD;
                                end
                            end else begin
                                state_d = GRANT;
                                y_d     = 1'b1;
                                timer_d = HOLD_LOAD;
                                tries_d = '0;
                            end
                        end else begin
                            // Wrong digits do not cut the entry short.
                            idx_d = idx_q + IDX_W'(1);
                            err_d = err_q | digit_bad;
                        end
                    end
                end
                GRANT: begin
                    if (timer_q == TMR_ONE) begin
                        state_d = ENTRY;
                        y_d     = 1'b0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                LOCKOUT: begin
                    if (timer_q == TMR_ONE) begin
                        state_d  = ENTRY;
                        locked_d = 1'b0;
                        tries_d  = '0;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                default: begin
                    state_d = ENTRY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ENTRY;
            idx_q    <= '0;
            err_q    <= 1'b0;
            tries_q  <= '0;
            timer_q  <= '0;
            y_q      <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            tries_q  <= tries_d;
            timer_q  <= timer_d;
            y_q      <= y_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    assign Y         = y_q;
    assign fail      = fail_q;
    assign locked    = locked_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_station_access_fsm.sv
// -----------------------------------------------------------------------------
// tb_station_access_fsm
//
// Each test task queues a cycle-by-cycle stimulus list. While driving a cycle
// the bench's behavioural model pushes the expected registered outputs onto a
// scoreboard queue; after the edge the entry is popped and compared. Each task
// also checks hand-derived totals (grant/lock/fail cycle counts).
// -----------------------------------------------------------------------------
module tb_station_access_fsm;

    localparam int CODE_W = 4;
    localparam int DIGITS = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [CODE_W-1:0]        code;
    logic                     code_valid;
    logic                     abort;
    logic [DIGITS*CODE_W-1:0] secret;
    logic                     Y;
    logic                     fail;
    logic                     locked;
    logic [2:0]               digit_idx;

    station_access_fsm #(
        .CODE_W(4), .DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .code(code),
        .code_valid(code_valid), .abort(abort), .secret(secret),
        .Y(Y), .fail(fail), .locked(locked), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        cv;
        logic        ab;
        logic [3:0]  code;
        logic [15:0] sec;
    } stim_t;

    typedef struct {
        logic       y;
        logic       f;
        logic       l;
        logic [2:0] idx;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int y_cnt, f_cnt, l_cnt, fl_cnt;
    logic [15:0] cur_sec = 16'hD5A3;

    // behavioural model state
    int   m_st, m_cnt, m_tries, m_rem;
    logic m_bad, m_y, m_f, m_l;

    task automatic add(input logic rst, input logic en, input logic cv,
                       input logic ab, input logic [3:0] c);
        stim_t s;
        s.rst = rst; s.en = en; s.cv = cv; s.ab = ab; s.code = c; s.sec = cur_sec;
        stim_q.push_back(s);
    endtask

    task automatic add_digit(input logic [3:0] c);
        add(1'b0, 1'b1, 1'b1, 1'b0, c);
    endtask

    // Digits are entered low nibble first.
    task automatic add_code(input logic [15:0] v);
        for (int k = 0; k < 4; k++) add_digit(v[4*k +: 4]);
    endtask

    task automatic add_idle(input int n, input logic en);
        for (int k = 0; k < n; k++) add(1'b0, en, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic model_step(input stim_t s);
        exp_t e;
        logic [3:0] want;
        if (s.rst) begin
            m_st = 0; m_cnt = 0; m_bad = 1'b0; m_tries = 0; m_rem = 0;
            m_y = 1'b0; m_f = 1'b0; m_l = 1'b0;
        end else if (s.en) begin
            m_f = 1'b0;
            if (m_st == 0) begin
                if (s.ab) begin
                    m_cnt = 0; m_bad = 1'b0;
                end else if (s.cv) begin
                    want = s.sec[4*m_cnt +: 4];
                    if (s.code != want) m_bad = 1'b1;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt = 0;
                        if (m_bad) begin
                            m_f = 1'b1;
                            m_tries++;
                            if (m_tries == 3) begin
                                m_st = 2; m_rem = 16; m_l = 1'b1;
                            end
                        end else begin
                            m_st = 1; m_rem = 4; m_y = 1'b1; m_tries = 0;
                        end
                        m_bad = 1'b0;
                    end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_st == 2) begin
                        m_l = 1'b0; m_tries = 0;
                    end
                    m_y = 1'b0;
                    m_st = 0;
                end
            end
        end
        e.y = m_y; e.f = m_f; e.l = m_l; e.idx = 3'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        reset = s.rst; enable = s.en; code_valid = s.cv; abort = s.ab;
        code = s.code; secret = s.sec;
        model_step(s);
    endtask

    task automatic clear_counts();
        y_cnt = 0; f_cnt = 0; l_cnt = 0; fl_cnt = 0;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        clear_counts();
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
        add_idle(2, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL reset_seq t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
        end
        checks++;
        if ({Y, fail, locked, digit_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, want 000000", {Y, fail, locked, digit_idx});
        end
    endtask

    task automatic test_grant();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        // secret changes after two digits; remaining digits follow new secret
        add_digit(4'h3);
        add_digit(4'hA);
        cur_sec = 16'h1234;
        add_digit(4'h2);
        add_digit(4'h1);
        add_idle(5, 1'b1);
        cur_sec = 16'hD5A3;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL grant t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
        end
        checks++;
        if (y_cnt != 8 || f_cnt != 0) begin
            errors++;
            $display("FAIL grant_totals: got y=%0d fail=%0d, want y=8 fail=0", y_cnt, f_cnt);
        end
    endtask

    task automatic test_wrong_then_right();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_code(16'hC5A3);
        add_idle(1, 1'b1);
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        // tries were cleared by the grant, so two wrong entries must not lock
        add_code(16'h0000);
        add_code(16'hD5A4);
        add_idle(1, 1'b1);
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL wrong_right t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
            if (locked) l_cnt++;
        end
        checks++;
        if (y_cnt != 8 || f_cnt != 3 || l_cnt != 0) begin
            errors++;
            $display("FAIL wrong_right_totals: got y=%0d fail=%0d lock=%0d, want 8 3 0", y_cnt, f_cnt, l_cnt);
        end
    endtask

    task automatic test_lockout();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_code(16'hC5A3);
        add_code(16'hC5A3);
        add_code(16'hC5A3);
        // digits and aborts during lockout are ignored
        for (int k = 0; k < 16; k++) add(1'b0, 1'b1, 1'b1, k[0], 4'h3);
        add_idle(2, 1'b1);
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL lockout t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
            if (locked) l_cnt++;
            if (fail && locked) fl_cnt++;
        end
        checks++;
        if (l_cnt != 16 || f_cnt != 3 || fl_cnt != 1 || y_cnt != 4) begin
            errors++;
            $display("FAIL lockout_totals: got lock=%0d fail=%0d both=%0d y=%0d, want 16 3 1 4",
                     l_cnt, f_cnt, fl_cnt, y_cnt);
        end
    endtask

    task automatic test_abort();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_digit(4'h3);
        add_digit(4'hA);
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        add_digit(4'h3);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
        add_idle(1, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL abort t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
        end
        checks++;
        if (y_cnt != 4 || f_cnt != 0 || digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL abort_totals: got y=%0d fail=%0d idx=%0d, want 4 0 0", y_cnt, f_cnt, digit_idx);
        end
    endtask

    task automatic test_enable();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_code(16'hD5A3);
        add_idle(2, 1'b1);
        for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 4'h3);
        add_idle(3, 1'b1);
        // fail pulse held while disabled; disabled digits not counted
        add_code(16'hC5A3);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 4'h3);
        add_idle(1, 1'b1);
        add_code(16'hC5A3);
        add_code(16'hC5A3);
        add_idle(5, 1'b1);
        add_idle(5, 1'b0);
        add_idle(12, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL enable t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
            if (locked) l_cnt++;
        end
        checks++;
        if (y_cnt != 9 || l_cnt != 21 || f_cnt != 6) begin
            errors++;
            $display("FAIL enable_totals: got y=%0d lock=%0d fail=%0d, want 9 21 6", y_cnt, l_cnt, f_cnt);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t  e;
        clear_counts();
        add_code(16'hC5A3);
        add_code(16'hC5A3);
        add_code(16'hC5A3);
        add_idle(4, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        add_idle(1, 1'b1);
        add_code(16'hD5A3);
        add_idle(5, 1'b1);
        add_digit(4'h3);
        add_digit(4'hB);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        add_code(16'hD5A3);
        add_idle(1, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        add_idle(2, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({Y, fail, locked, digit_idx} !== {e.y, e.f, e.l, e.idx}) begin
                errors++;
                $display("FAIL reset_mid t=%0t: got Y=%b fail=%b locked=%b idx=%0d, want Y=%b fail=%b locked=%b idx=%0d",
                         $time, Y, fail, locked, digit_idx, e.y, e.f, e.l, e.idx);
            end
            if (Y) y_cnt++;
            if (fail) f_cnt++;
            if (locked) l_cnt++;
        end
        checks++;
        if (y_cnt != 6 || f_cnt != 3 || l_cnt != 5) begin
            errors++;
            $display("FAIL reset_mid_totals: got y=%0d fail=%0d lock=%0d, want 6 3 5", y_cnt, f_cnt, l_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; code = '0; code_valid = 1'b0;
        abort = 1'b0; secret = 16'hD5A3;
        test_reset();
        test_grant();
        test_wrong_then_right();
        test_lockout();
        test_abort();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
